// File: rtl/dot_product_engine_pkg.sv
// dot_pkg: shared state encoding and default widths for dot_product_engine.
package dot_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dot_state_t;

  localparam int DOT_DATA_WIDTH = 8;
  localparam int DOT_ACC_WIDTH  = 24;
  localparam int DOT_LEN        = 8;

endpackage

// File: rtl/dot_product_engine_if.sv
// dot_product_engine_if: FIFO-side and control/result signals of one engine.
//   start            begin a dot product (sampled in IDLE only)
//   a_/b_empty       FIFO empty flags
//   a_/b_data        FIFO registered read data (valid the cycle after rden)
//   a_/b_rden        pop requests, always identical
//   busy/done/result engine status and dot product
// master = upstream/control side, slave = engine side.
interface dot_product_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
);
  logic                  start;
  logic                  a_empty;
  logic                  b_empty;
  logic [DATA_WIDTH-1:0] a_data;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  a_rden;
  logic                  b_rden;
  logic                  busy;
  logic                  done;
  logic [ACC_WIDTH-1:0]  result;

  modport master (
    output start, a_empty, b_empty, a_data, b_data,
    input  a_rden, b_rden, busy, done, result
  );

  modport slave (
    input  start, a_empty, b_empty, a_data, b_data,
    output a_rden, b_rden, busy, done, result
  );
endinterface

// File: rtl/dot_product_engine_mac_unit.sv
// mac_unit: registered unsigned multiply-accumulate.
//   clk, rst_n  clock, async active-low reset (acc -> 0)
//   clr_i       synchronous clear, wins over en_i
//   en_i        add a_i*b_i into the accumulator this edge
//   a_i, b_i    operands
//   acc_o       accumulator, wraps modulo 2^ACC_WIDTH
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic [ACC_WIDTH-1:0]    acc_d;

  assign prod  = a_i * b_i;
  assign acc_d = acc_q + ACC_WIDTH'(prod);
  assign acc_o = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= acc_d;
  end
endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: pops LEN element pairs in lockstep from FIFO A and B
// after a start, accumulates the unsigned products and presents the sum with
// a one-cycle done pulse.
//   clk, rst_n  clock, async active-low reset
//   bus         dot_product_engine_if.slave (start, FIFO flags/data, rden,
//               busy, done, result)
module dot_product_engine
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH = DOT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DOT_ACC_WIDTH,
  parameter int LEN        = DOT_LEN
) (
  input logic                 clk,
  input logic                 rst_n,
  dot_product_engine_if.slave bus
);
  localparam int            CW    = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  dot_state_t           state_q;
  logic [CW-1:0]        issued_q;
  logic                 pop_d1_q;
  logic [ACC_WIDTH-1:0] result_q;
  logic [ACC_WIDTH-1:0] acc;
  logic                 pop;
  logic                 clr;

  // Both FIFOs pop together or not at all; an empty on either side stalls.
  assign pop = (state_q == RUN) && !bus.a_empty && !bus.b_empty && (issued_q < LEN_C);
  assign clr = (state_q == IDLE) && bus.start;

  assign bus.a_rden = pop;
  assign bus.b_rden = pop;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  // In DONE the accumulator already holds the final sum; result_q captures
  // it on the way out so the value stays put until the next DONE.
  assign bus.result = (state_q == DONE) ? acc : result_q;

  mac_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .en_i  (pop_d1_q),
    .a_i   (bus.a_data),
    .b_i   (bus.b_data),
    .acc_o (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      issued_q <= '0;
      pop_d1_q <= 1'b0;
      result_q <= '0;
    end else begin
      // FIFO data is registered, so the product lands one cycle after rden.
      pop_d1_q <= pop;
      case (state_q)
        IDLE: if (bus.start) begin
          issued_q <= '0;
          state_q  <= RUN;
        end
        RUN: if (pop) begin
          issued_q <= issued_q + CW'(1);
          if (issued_q == LEN_C - CW'(1)) state_q <= DRAIN;
        end
        // The last product is accumulated on the closing edge of DRAIN.
        DRAIN: state_q <= DONE;
        DONE: begin
          result_q <= acc;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench: two engines (ACC_WIDTH 24 and 16) share one pair of
// behavioural FIFOs; stimulus pushes hand-computed results and done cycles,
// a negedge monitor pops and compares whenever done is seen.
module tb_dot_product_engine;
  import dot_pkg::*;

  typedef struct {
    longint res;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dot_product_engine_if #(.DATA_WIDTH(8), .ACC_WIDTH(24)) bus ();
  dot_product_engine_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) bus16 ();

  dot_product_engine #(.DATA_WIDTH(8), .ACC_WIDTH(24), .LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  dot_product_engine #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16));

  logic       start = 1'b0;
  logic       b_gate = 1'b0;
  logic       a_empty_r = 1'b1;
  logic       b_empty_r = 1'b1;
  logic [7:0] a_data_r = '0;
  logic [7:0] b_data_r = '0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  exp_t       sb[$];
  exp_t       sb16[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         pops_a = 0;
  int         pops_b = 0;
  logic       lock_err = 1'b0;

  assign bus.start     = start;
  assign bus.a_empty   = a_empty_r;
  assign bus.b_empty   = b_empty_r | b_gate;
  assign bus.a_data    = a_data_r;
  assign bus.b_data    = b_data_r;
  assign bus16.start   = start;
  assign bus16.a_empty = a_empty_r;
  assign bus16.b_empty = b_empty_r | b_gate;
  assign bus16.a_data  = a_data_r;
  assign bus16.b_data  = b_data_r;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFOs: registered read data, empty flag updates on the edge.
  always @(posedge clk) begin
    if (bus.a_rden && qa.size() > 0) a_data_r <= qa.pop_front();
    if (bus.b_rden && qb.size() > 0) b_data_r <= qb.pop_front();
    a_empty_r <= (qa.size() == 0);
    b_empty_r <= (qb.size() == 0);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pops_a   = 0;
      pops_b   = 0;
      lock_err = 1'b0;
    end else begin
      if (bus.a_rden) pops_a++;
      if (bus.b_rden) pops_b++;
      if (bus.a_rden != bus.b_rden) lock_err = 1'b1;
      if (bus.done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("done_cycle", cyc, e.cyc);
          chk("rden_a_count", pops_a, 8);
          chk("rden_b_count", pops_b, 8);
          chk("lockstep", lock_err, 0);
        end
        pops_a   = 0;
        pops_b   = 0;
        lock_err = 1'b0;
      end
      if (bus16.done) begin
        if (sb16.size() == 0) chk("unexpected_done16", 1, 0);
        else begin
          e = sb16.pop_front();
          chk("result16", bus16.result, e.res);
          chk("done_cycle16", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  task automatic expect_res(input longint r24, input longint r16, input int dcyc);
    sb.push_back('{res: r24, cyc: dcyc});
    sb16.push_back('{res: r16, cyc: dcyc});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((sb.size() != 0 || sb16.size() != 0) && k < bound) begin
      tick();
      k++;
    end
    if (k >= bound) chk("timeout_pending", sb.size() + sb16.size(), 0);
  endtask

  initial begin
    int s;
    int f;
    logic bad;
    rst_n = 1'b0;
    tick(3);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_rden", bus.a_rden | bus.b_rden, 0);
    chk("reset_result", bus.result, 0);
    rst_n = 1'b1;
    tick();

    // Basic: A=1..8, B=2
    for (int i = 1; i <= 8; i++) push(8'(i), 8'd2);
    tick(2);
    s = cyc;
    expect_res(72, 72, s + 10);
    pulse_start();
    wait_idle(40);
    tick(3);
    chk("basic_fifos_empty", qa.size() + qb.size(), 0);
    chk("basic_result_hold", bus.result, 72);

    // Max values, wraps in the 16-bit instance
    for (int i = 0; i < 8; i++) push(8'd255, 8'd255);
    tick(2);
    s = cyc;
    expect_res(520200, 61448, s + 10);
    pulse_start();
    wait_idle(40);

    // Stall: B reads empty for 3 cycles after its 4th pop
    for (int i = 1; i <= 8; i++) push(8'(i), 8'd2);
    tick(2);
    s = cyc;
    expect_res(72, 72, s + 13);
    pulse_start();
    tick(4);
    b_gate = 1'b1;
    repeat (3) begin
      #3;
      chk("stall_a_rden_low", bus.a_rden, 0);
      tick();
    end
    b_gate = 1'b0;
    wait_idle(40);

    // Back-to-back, with an ignored start while busy
    for (int i = 0; i < 8; i++) push(8'd1, 8'd1);
    for (int i = 0; i < 8; i++) push(8'd3, 8'd4);
    tick(2);
    s = cyc;
    expect_res(8, 8, s + 10);
    expect_res(96, 96, s + 21);
    pulse_start();
    tick(3);
    pulse_start();
    tick(6);
    pulse_start();
    wait_idle(60);
    tick(2);
    chk("b2b_idle_after", bus.busy, 0);

    // Reset after the 5th pop
    for (int i = 0; i < 8; i++) push(8'd5, 8'd5);
    tick(2);
    pulse_start();
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rden", bus.a_rden | bus.b_rden, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_result", bus.result, 0);
    chk("rst_mid_result16", bus16.result, 0);
    qa.delete();
    qb.delete();
    tick(2);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push(8'd1, 8'd1);
    tick(2);
    s = cyc;
    expect_res(8, 8, s + 10);
    pulse_start();
    wait_idle(40);

    // Empty at start, FIFOs filled later
    pulse_start();
    bad = 1'b0;
    repeat (20) begin
      #3;
      if (bus.busy !== 1'b1 || bus.a_rden !== 1'b0 || bus.b_rden !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("empty_start_waiting", bad, 0);
    f = cyc;
    for (int i = 1; i <= 8; i++) push(8'(i), 8'(9 - i));
    expect_res(120, 120, f + 10);
    wait_idle(40);

    tick(5);
    chk("final_idle", bus.busy, 0);
    chk("final_sb_empty", sb.size() + sb16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dot_product_engine.md
# dot_product_engine

Streaming multiply-accumulate consumer that sits directly downstream of a pair of FIFO instances (row operand A, vector operand B). On a start pulse it pops exactly LEN element pairs from the two FIFOs in lockstep and accumulates their unsigned products. It then presents the dot product with a one-cycle done pulse. Multiple instances run in parallel, one per matrix row, sharing the B stream source.

## Interface
- DATA_WIDTH, 8, width of each FIFO element
- ACC_WIDTH, 24, accumulator and result width (≥ 2*DATA_WIDTH)
- LEN, 8, element pairs consumed per dot product (≥ 1)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a new dot product; sampled only in IDLE
- a_empty  input  1  empty flag of FIFO A
- b_empty  input  1  empty flag of FIFO B
- a_data  input  DATA_WIDTH  FIFO A o_data (registered, valid the cycle after rden)
- b_data  input  DATA_WIDTH  FIFO B o_data (registered, valid the cycle after rden)
- a_rden  output  1  pop request to FIFO A
- b_rden  output  1  pop request to FIFO B
- busy  output  1  high in any state other than IDLE
- done  output  1  single-cycle pulse, result valid
- result  output  ACC_WIDTH  dot product, held until next start

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE; all outputs 0; accumulator and counters 0.
- IDLE: start=1 → clear accumulator and issue counter, go RUN. start is ignored in all other states.
- RUN: a_rden = b_rden = !a_empty && !b_empty && (issued < LEN). Both rden signals are always identical; never pop one FIFO alone. Each pop increments issued. Once issued reaches LEN (on the edge of the final pop) → DRAIN.
- Pipeline: pop_d1 register = rden delayed one cycle. When pop_d1=1, acc <= acc + zero_extend(a_data*b_data).
- DRAIN: one cycle. The final product is accumulated on its closing edge → DONE.
- DONE: done=1 for one cycle, result = acc, then → IDLE.
- Arithmetic: unsigned DATA_WIDTH×DATA_WIDTH product, zero-extended to ACC_WIDTH. Sum wraps modulo 2^ACC_WIDTH with no saturation and no overflow flag.
- Counters: issued and accumulated counters are $clog2(LEN+1) bits wide.
- Empty stall: if either FIFO is empty in RUN, no pop occurs and no products are lost. Processing resumes on the first cycle both are non-empty.
- Reset mid-operation: immediately returns to IDLE with outputs cleared. Partial accumulation is discarded. Elements already popped from the FIFOs are not restored.

## Timing
- rden is combinational from the registered state and the empty inputs. There is no combinational path from a_data/b_data to any output.
- Unstalled case, start sampled high at the end of cycle 0:
  - RUN in cycles 1..LEN, rden high in each of those cycles
  - products accumulated at the ends of cycles 2..LEN+1
  - DRAIN in cycle LEN+1
  - done=1 in cycle LEN+2
  - IDLE in cycle LEN+3, where a new start can be accepted
- Each stall cycle delays done by exactly one cycle.
- result updates only in DONE and is stable at all other times, including through subsequent IDLE.
- busy=1 from cycle 1 through the DONE cycle inclusive.

## Structure
- Shared package dot_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dot_state_t
  - default width constants DOT_DATA_WIDTH=8, DOT_ACC_WIDTH=24, DOT_LEN=8
- One sub-module, mac_unit: registered accumulator with synchronous clear, enable, unsigned multiply-add and async reset. The FSM, counters and rden gating stay in dot_product_engine.

## Test plan
- Basic: A=1..8, B=all 2, both FIFOs pre-filled, start pulse. Required:
  - exactly 8 rden cycles
  - done in cycle 10
  - result=72
  - both FIFOs empty afterwards
- Max values: A=B=255 ×8 → result=520200. The same stimulus with ACC_WIDTH=16 → result=61448 (wrap).
- Stall: B is empty for 3 cycles after its 4th element, with A full. Required:
  - a_rden stays low during the stall (lockstep)
  - done is delayed exactly 3 cycles
  - result matches the unstalled value
- Back-to-back: two starts with 16 elements queued, A=1 and B=1 for the first 8, then A=3 and B=4. Required:
  - result=8, then result=96
  - the second start is accepted in the cycle after done
  - a start pulsed while busy is ignored
- Reset mid-run: assert rst_n low after the 5th pop. Required:
  - all outputs are 0 immediately
  - after release, a start with 8 fresh elements (A=1, B=1) gives result=8
- Empty at start: both FIFOs empty, start pulsed. Required:
  - busy=1 and rden stays low indefinitely
  - filling the FIFOs later completes normally with the correct result
